// File: rtl/chronologic.sv
// -----------------------------------------------------------------------------
// chronologic -- embedded single-clock monitor for the implication
//                "a |-> $fell(b)".
//
// At every rising edge with en=1 the monitor classifies the sampled (a, b)
// pair as vacuous (a=0), pass (a=1 and b fell since the previous edge) or
// fail (a=1 and b did not fall).
// The verdict appears one cycle later as a registered pulse.
// Saturating statistics, a sticky error flag and the index of the first
// failing edge are kept for a status/CSR reader.
//
// There is no handshake.
// Every edge is an independent sample.
// Outputs are registered and stay stable for the whole clock period after the
// edge that produced them.
//
// Parameters:
//   CNT_W  width of pass/fail/vacuous counters (>= 2)
//   TS_W   width of cycle counter and first-fail timestamp (>= 2)
//
// Ports:
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   en              evaluation enable (b history is tracked regardless)
//   clr             synchronous clear of statistics, err and timestamp
//   a               antecedent
//   b               monitored signal
//   pass            1-cycle pulse: non-vacuous success sampled
//   fail            1-cycle pulse: failure sampled
//   vacuous         1-cycle pulse: en=1 and a=0 sampled
//   err             sticky: at least one failure since reset/clear
//   pass_cnt        saturating pass count
//   fail_cnt        saturating fail count
//   vac_cnt         saturating vacuous count
//   cycle_cnt       edges since reset release (wraps)
//   first_fail_cyc  edge index of the first failure, valid while err=1
// -----------------------------------------------------------------------------
module chronologic #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic             pass,
    output logic             fail,
    output logic             vacuous,
    output logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] vac_cnt,
    output logic [TS_W-1:0]  cycle_cnt,
    output logic [TS_W-1:0]  first_fail_cyc
);

    // Statistics counters stick at all-ones instead of wrapping, so a reader
    // can tell "many" from "few".
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    logic             b_prev_q,         b_prev_d;
    logic             pass_q,           pass_d;
    logic             fail_q,           fail_d;
    logic             vac_q,            vac_d;
    logic             err_q,            err_d;
    logic [CNT_W-1:0] pass_cnt_q,       pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q,       fail_cnt_d;
    logic [CNT_W-1:0] vac_cnt_q,        vac_cnt_d;
    logic [TS_W-1:0]  cycle_cnt_q,      cycle_cnt_d;
    logic [TS_W-1:0]  first_fail_cyc_q, first_fail_cyc_d;

    // Falling edge of b between the previous sample and this one.
    logic fell;
    assign fell = b_prev_q & ~b;

    always_comb begin
        // History and the free-running edge index advance on every edge,
        // independent of en and clr.
        b_prev_d         = b;
        cycle_cnt_d      = cycle_cnt_q + TS_W'(1);

        pass_d           = 1'b0;
        fail_d           = 1'b0;
        vac_d            = 1'b0;
        err_d            = err_q;
        pass_cnt_d       = pass_cnt_q;
        fail_cnt_d       = fail_cnt_q;
        vac_cnt_d        = vac_cnt_q;
        first_fail_cyc_d = first_fail_cyc_q;

        if (clr) begin
            // clr takes priority over any verdict on the same edge.
            err_d            = 1'b0;
            pass_cnt_d       = '0;
            fail_cnt_d       = '0;
            vac_cnt_d        = '0;
            first_fail_cyc_d = '0;
        end else if (en) begin
            if (!a) begin
                vac_d     = 1'b1;
                vac_cnt_d = sat_inc(vac_cnt_q);
            end else if (fell) begin
                pass_d     = 1'b1;
                pass_cnt_d = sat_inc(pass_cnt_q);
            end else begin
                fail_d     = 1'b1;
                fail_cnt_d = sat_inc(fail_cnt_q);
                err_d      = 1'b1;
                // Timestamp is the pre-increment index of this edge.
                if (!err_q) begin
                    first_fail_cyc_d = cycle_cnt_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_prev_q         <= 1'b0;
            pass_q           <= 1'b0;
            fail_q           <= 1'b0;
            vac_q            <= 1'b0;
            err_q            <= 1'b0;
            pass_cnt_q       <= '0;
            fail_cnt_q       <= '0;
            vac_cnt_q        <= '0;
            cycle_cnt_q      <= '0;
            first_fail_cyc_q <= '0;
        end else begin
            b_prev_q         <= b_prev_d;
            pass_q           <= pass_d;
            fail_q           <= fail_d;
            vac_q            <= vac_d;
            err_q            <= err_d;
            pass_cnt_q       <= pass_cnt_d;
            fail_cnt_q       <= fail_cnt_d;
            vac_cnt_q        <= vac_cnt_d;
            cycle_cnt_q      <= cycle_cnt_d;
            first_fail_cyc_q <= first_fail_cyc_d;
        end
    end

    assign pass           = pass_q;
    assign fail           = fail_q;
    assign vacuous        = vac_q;
    assign err            = err_q;
    assign pass_cnt       = pass_cnt_q;
    assign fail_cnt       = fail_cnt_q;
    assign vac_cnt        = vac_cnt_q;
    assign cycle_cnt      = cycle_cnt_q;
    assign first_fail_cyc = first_fail_cyc_q;

endmodule

// File: tb/tb_chronologic.sv
module tb_chronologic;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;

    always #5 clk = ~clk;

    // Full-width instance.
    logic        pass, fail, vacuous, err;
    logic [15:0] pass_cnt, fail_cnt, vac_cnt;
    logic [31:0] cycle_cnt, first_fail_cyc;

    // Narrow instance: exercises saturation (CNT_W=2) and cycle wrap (TS_W=4).
    logic        s_pass, s_fail, s_vacuous, s_err;
    logic [1:0]  s_pass_cnt, s_fail_cnt, s_vac_cnt;
    logic [3:0]  s_cycle_cnt, s_first_fail_cyc;

    chronologic #(.CNT_W(16), .TS_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .pass(pass), .fail(fail), .vacuous(vacuous), .err(err),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .vac_cnt(vac_cnt),
        .cycle_cnt(cycle_cnt), .first_fail_cyc(first_fail_cyc)
    );

    chronologic #(.CNT_W(2), .TS_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .pass(s_pass), .fail(s_fail), .vacuous(s_vacuous), .err(s_err),
        .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt), .vac_cnt(s_vac_cnt),
        .cycle_cnt(s_cycle_cnt), .first_fail_cyc(s_first_fail_cyc)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    // Expected verdict per edge: {pass, fail, vacuous}.
    logic [2:0] exp_q[$];

    // Reference model: events counted as plain integers since reset/clear.
    bit b_hist[$];
    int m_pass, m_fail, m_vac, m_cycle, m_ffc;
    bit m_err;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic model_reset();
        b_hist.delete();
        exp_q.delete();
        m_pass = 0; m_fail = 0; m_vac = 0; m_cycle = 0; m_ffc = 0; m_err = 0;
    endtask

    // One sampled edge of the property "a implies b just fell".
    task automatic model_edge(input bit ia, input bit ib, input bit ien, input bit iclr);
        bit prev;
        bit fell_now;
        prev = (b_hist.size() == 0) ? 1'b0 : b_hist[$];
        fell_now = prev && !ib;
        b_hist.push_back(ib);
        if (iclr) begin
            m_pass = 0; m_fail = 0; m_vac = 0; m_err = 0; m_ffc = 0;
            exp_q.push_back(3'b000);
        end else if (!ien) begin
            exp_q.push_back(3'b000);
        end else if (!ia) begin
            m_vac++;
            exp_q.push_back(3'b001);
        end else if (fell_now) begin
            m_pass++;
            exp_q.push_back(3'b100);
        end else begin
            m_fail++;
            if (!m_err) m_ffc = m_cycle;
            m_err = 1;
            exp_q.push_back(3'b010);
        end
        m_cycle++;
    endtask

    task automatic check_all();
        logic [2:0] v;
        if (exp_q.size() == 0) begin
            check_eq("exp_q_empty", 32'd1, 32'd0);
            return;
        end
        v = exp_q.pop_front();
        check_eq("pass", {31'd0, pass}, {31'd0, v[2]});
        check_eq("fail", {31'd0, fail}, {31'd0, v[1]});
        check_eq("vacuous", {31'd0, vacuous}, {31'd0, v[0]});
        check_eq("err", {31'd0, err}, {31'd0, m_err});
        check_eq("pass_cnt", {16'd0, pass_cnt}, sat(m_pass, 65535));
        check_eq("fail_cnt", {16'd0, fail_cnt}, sat(m_fail, 65535));
        check_eq("vac_cnt", {16'd0, vac_cnt}, sat(m_vac, 65535));
        check_eq("cycle_cnt", cycle_cnt, m_cycle);
        check_eq("first_fail_cyc", first_fail_cyc, m_ffc);
        check_eq("s_fail", {31'd0, s_fail}, {31'd0, v[1]});
        check_eq("s_pass_cnt", {30'd0, s_pass_cnt}, sat(m_pass, 3));
        check_eq("s_fail_cnt", {30'd0, s_fail_cnt}, sat(m_fail, 3));
        check_eq("s_vac_cnt", {30'd0, s_vac_cnt}, sat(m_vac, 3));
        check_eq("s_cycle_cnt", {28'd0, s_cycle_cnt}, m_cycle % 16);
        check_eq("s_first_fail_cyc", {28'd0, s_first_fail_cyc}, m_ffc % 16);
    endtask

    // ---------------- driver tasks ----------------
    // Called away from the clock edge; checks 1 time unit after the edge.
    task automatic step(input bit ia, input bit ib, input bit ien, input bit iclr);
        a = ia; b = ib; en = ien; clr = iclr;
        @(posedge clk);
        model_edge(ia, ib, ien, iclr);
        #1;
        check_all();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"}, {28'd0, pass, fail, vacuous, err}, 32'd0);
        check_eq({tag, "_cnts"}, {pass_cnt, fail_cnt}, 32'd0);
        check_eq({tag, "_vac"}, {16'd0, vac_cnt}, 32'd0);
        check_eq({tag, "_cyc"}, cycle_cnt, 32'd0);
        check_eq({tag, "_ffc"}, first_fail_cyc, 32'd0);
        check_eq({tag, "_small"}, {14'd0, s_pass_cnt, s_fail_cnt, s_vac_cnt, s_cycle_cnt, s_first_fail_cyc}, 32'd0);
    endtask

    // Asserts reset between clock edges and confirms outputs clear without a clock.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(tag);
        model_reset();
        @(negedge clk);
        a = 1'b0; b = 1'b0; en = 1'b1; clr = 1'b0;
        rst_n = 1'b1;
    endtask

    logic [1:0] seq_ab [0:14];

    task automatic run_seq(input int en_lo, input int en_hi, input int clr_at);
        for (int i = 0; i < 15; i++) begin
            step(seq_ab[i][1], seq_ab[i][0],
                 !(i >= en_lo && i <= en_hi), (i == clr_at));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        seq_ab = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00,
                   2'b11, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};

        // Directed sequence, always enabled.
        do_reset("rst0");
        run_seq(-1, -1, -1);
        check_eq("s1_pass_cnt", {16'd0, pass_cnt}, 32'd2);
        check_eq("s1_fail_cnt", {16'd0, fail_cnt}, 32'd6);
        check_eq("s1_vac_cnt", {16'd0, vac_cnt}, 32'd7);
        check_eq("s1_err", {31'd0, err}, 32'd1);
        check_eq("s1_first_fail", first_fail_cyc, 32'd2);
        check_eq("s1_small_sat", {30'd0, s_fail_cnt}, 32'd3);

        // Fail on the very first edge, with b held low and held high.
        do_reset("rst1");
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("s2_fail_b0", {31'd0, fail}, 32'd1);
        check_eq("s2_ffc_b0", first_fail_cyc, 32'd0);
        do_reset("rst2");
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("s2_fail_b1", {31'd0, fail}, 32'd1);

        // Enable low on edges 3..5; history still tracked.
        do_reset("rst3");
        run_seq(3, 5, -1);
        check_eq("s3_pass_cnt", {16'd0, pass_cnt}, 32'd1);
        check_eq("s3_vac_cnt", {16'd0, vac_cnt}, 32'd5);

        // Clear on edge 9.
        do_reset("rst4");
        run_seq(-1, -1, 9);
        check_eq("s4_fail_cnt", {16'd0, fail_cnt}, 32'd3);
        check_eq("s4_first_fail", first_fail_cyc, 32'd10);
        check_eq("s4_pass_cnt", {16'd0, pass_cnt}, 32'd0);

        // Five consecutive fails saturate the 2-bit counter.
        do_reset("rst5");
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("s5_small_fail_sat", {30'd0, s_fail_cnt}, 32'd3);
        check_eq("s5_fail_cnt", {16'd0, fail_cnt}, 32'd5);

        // Async reset mid-sequence clears b history.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        do_reset("rst6");
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check_eq("s6_fail_after_rst", {31'd0, fail}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));
            if ($urandom_range(0, 149) == 0) do_reset("rst_rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/chronologic.md
# chronologic

Synthesizable single-clock protocol checker for the implication "whenever `a` is sampled high, `b` must have fallen on that same sample," i.e. `a |-> $fell(b)`. On every clock it registers a pass, fail or vacuous verdict and keeps saturating statistics. It also records a sticky error flag and the cycle index of the first failure. It sits beside the logic it monitors as an embedded assertion monitor and can be read by a status/CSR block.

## Interface
Parameters:
- `CNT_W`, default 16: width of the pass, fail and vacuous counters (≥2).
- `TS_W`, default 32: width of the cycle counter and first-fail timestamp (≥2).

Ports:
- `clk` input 1: clock. All sampling is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: evaluation enable. At 0 no verdicts are produced, but `b` history still tracks.
- `clr` input 1: synchronous clear of statistics.
- `a` input 1: antecedent.
- `b` input 1: monitored signal.
- `pass` output 1: one-cycle pulse, a non-vacuous success was sampled.
- `fail` output 1: one-cycle pulse, a failure was sampled.
- `vacuous` output 1: one-cycle pulse, `en=1` and `a=0`.
- `err` output 1: sticky, at least one failure since reset/clear.
- `pass_cnt` output CNT_W: saturating count of passes.
- `fail_cnt` output CNT_W: saturating count of fails.
- `vac_cnt` output CNT_W: saturating count of vacuous evaluations.
- `cycle_cnt` output TS_W: number of rising edges since reset release. Wraps.
- `first_fail_cyc` output TS_W: sample index of the first failure. Valid while `err=1`.

## Operation
- Internal register `b_prev` holds `b` from the previous rising edge.
  - Updated every edge, regardless of `en` or `clr`.
  - Reset value 0, so the first sample after reset sees history 0.
- `fell = b_prev & ~b`, using values sampled at the current edge.
- Verdict at each edge with `en=1`:
  - `a=0`: vacuous.
  - `a=1` and `fell`: pass.
  - `a=1` and not `fell`: fail. This covers `b` held at 0, held at 1, or rising.
- `en=0`: no verdict, no pulses, counters hold.
- Fail actions:
  - `fail_cnt` increments.
  - `err` is set.
  - If `err` was 0, `first_fail_cyc` is loaded with the current `cycle_cnt` value (its pre-increment value, i.e. the 0-based index of this edge).
- Counters saturate at all-ones and never wrap. `cycle_cnt` is the exception: it wraps modulo 2^TS_W.
- `clr=1` at an edge:
  - Zeroes `pass_cnt`, `fail_cnt`, `vac_cnt`, `err` and `first_fail_cyc`.
  - Suppresses all pulses for that edge; `clr` wins over a simultaneous verdict.
  - Does not affect `b_prev` or `cycle_cnt`.
- Reset values: every output and `b_prev` are 0.
- Asynchronous reset mid-operation:
  - All state clears immediately.
  - History restarts at 0, so the first post-reset sample with `a=1` fails unless `b` fell from 0, which is impossible. It always fails.

## Timing
- Inputs are sampled at the rising edge. Verdict pulses are registered and are high for exactly the clock period following the sampling edge.
- Latency is one cycle from sample to pulse. Counters and `err` update at the same edge as the pulse.
- At most one of `pass`/`fail`/`vacuous` is high in any cycle.
- Back-to-back evaluations every cycle are supported. There is no handshake.
- `cycle_cnt` increments at every edge after reset release; the first edge is index 0.

## Test plan
Common setup for scenarios 1, 3 and 4: `en=1`, `clr=0`, sample index 0 is the first edge after reset release. The 15 sampled `(a,b)` pairs for edges 0–14 are:
(0,0)(0,0)(1,0)(0,1)(1,0)(0,0)(1,1)(0,0)(1,1)(1,0)(1,0)(0,0)(1,0)(0,0)(1,0)

1. Apply the 15-edge sequence above.
   - Fails at edges 2, 6, 8, 10, 12, 14.
   - Passes at edges 4, 9.
   - Final counts: `pass_cnt=2`, `fail_cnt=6`, `vac_cnt=7`, `err=1`, `first_fail_cyc=2`.
2. Immediately after reset, drive `a=1,b=0` at edge 0 → `fail`=1 the next cycle and `first_fail_cyc=0`. Repeat with `a=1,b=1` → also `fail`.
3. Drive the scenario-1 sequence with `en=0` on edges 3–5.
   - Edge 4 produces no verdict and no pulse.
   - Final counts: `pass_cnt=1`, `vac_cnt=5`.
   - History is still tracked, so edge 9 still passes.
4. Assert `clr` at edge 9 of the scenario-1 sequence.
   - No pulse at edge 9.
   - Counters zero after edge 9.
   - Subsequent fails at 10, 12, 14 give `fail_cnt=3`, `first_fail_cyc=10`.
5. Use `CNT_W=2` and drive 5 consecutive fails → `fail_cnt` holds at 3.
6. Assert `rst_n` low asynchronously mid-sequence.
   - All outputs go to 0 without waiting for a clock edge.
   - `b_prev` is cleared: `b=1` before reset then `b=0` at the first post-reset edge with `a=1` gives `fail`.
